regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ
// writeback requesters, plus a pending-destination scoreboard for hazard checks.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_addr_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic                    iss_valid_i,
    input  logic [4:0]              iss_rd_addr_i,
    input  logic [4:0]              rs1_addr_i,
    input  logic [4:0]              rs2_addr_i,
    output logic                    rs1_busy_o,
    output logic                    rs2_busy_o,
    output logic [31:0]             busy_o,
    output logic [4:0]              rd_addr_o,
    output logic [XLEN-1:0]         rd_wr_data_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] winner;
    logic             grant_found;
    logic             xfer;
    logic [31:0]      busy_q;
    logic [31:0]      busy_next;

    // Search starts one past the previous winner and wraps, so every requester
    // is reached within NUM_REQ transfers.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid_i[(int'(last_grant_q) + 1 + i) % NUM_REQ]) begin
                grant_found = 1'b1;
                winner      = IDX_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
            end
        end
    end

    // No grant can be issued while reset is held.
    assign xfer = rst_i && grant_found;

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Clear comes from the write leaving the port this cycle; a set of the
    // same register is applied afterwards so it wins.
    always_comb begin
        busy_next = busy_q;
        if (rd_addr_o != 5'd0) begin
            busy_next[rd_addr_o] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_addr_i != 5'd0)) begin
            busy_next[iss_rd_addr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            rd_addr_o    <= '0;
            rd_wr_data_o <= '0;
            busy_q       <= '0;
        end else begin
            busy_q <= busy_next;
            if (xfer) begin
                last_grant_q <= winner;
                rd_addr_o    <= req_rd_addr_i[int'(winner)*5 +: 5];
                rd_wr_data_o <= req_data_i[int'(winner)*XLEN +: XLEN];
            end else begin
                rd_addr_o    <= '0;
                rd_wr_data_o <= '0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: round-robin order, write latency,
// scoreboard set/clear priority, rd=0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*5-1:0]    req_rd_addr_i;
    logic [NUM_REQ*XLEN-1:0] req_data_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    iss_valid_i;
    logic [4:0]              iss_rd_addr_i;
    logic [4:0]              rs1_addr_i;
    logic [4:0]              rs2_addr_i;
    logic                    rs1_busy_o;
    logic                    rs2_busy_o;
    logic [31:0]             busy_o;
    logic [4:0]              rd_addr_o;
    logic [XLEN-1:0]         rd_wr_data_o;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_rd_addr_i(req_rd_addr_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .iss_valid_i  (iss_valid_i),
        .iss_rd_addr_i(iss_rd_addr_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .busy_o       (busy_o),
        .rd_addr_o    (rd_addr_o),
        .rd_wr_data_o (rd_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid_i[k]              = v;
        req_rd_addr_i[k*5 +: 5]     = rd;
        req_data_i[k*XLEN +: XLEN]  = d;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i         = 1'b0;
        req_valid_i   = '0;
        req_rd_addr_i = '0;
        req_data_i    = '0;
        iss_valid_i   = 1'b0;
        iss_rd_addr_i = '0;
        rs1_addr_i    = '0;
        rs2_addr_i    = '0;
        set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
        set_req(1, 1'b1, 5'd6, 32'hBBBB_0002);
        set_req(2, 1'b1, 5'd7, 32'hCCCC_0003);

        // Reset held with every requester valid: no grant allowed.
        #1;
        check("rst_ready", req_ready_o, 3'b000);
        cycle();
        cycle();
        check("rst_ready_held", req_ready_o, 3'b000);
        check("rst_rd_addr", rd_addr_o, 5'd0);
        check("rst_rd_data", rd_wr_data_o, 32'h0);
        check("rst_busy", busy_o, 32'h0);

        // All three valid: grants 0,1,2,0, one transfer per cycle.
        rst_i = 1'b1;
        #1;
        check("rr_ready0", req_ready_o, 3'b001);
        cycle();
        check("rr_rd0", rd_addr_o, 5'd5);
        check("rr_data0", rd_wr_data_o, 32'hAAAA_0001);
        check("rr_ready1", req_ready_o, 3'b010);
        cycle();
        check("rr_rd1", rd_addr_o, 5'd6);
        check("rr_data1", rd_wr_data_o, 32'hBBBB_0002);
        check("rr_ready2", req_ready_o, 3'b100);
        cycle();
        check("rr_rd2", rd_addr_o, 5'd7);
        check("rr_data2", rd_wr_data_o, 32'hCCCC_0003);
        check("rr_ready3", req_ready_o, 3'b001);
        cycle();
        check("rr_rd3", rd_addr_o, 5'd5);

        // Requester 0 was just served and leaves; requester 1 is granted next.
        set_req(0, 1'b0, 5'd5, 32'hAAAA_0001);
        #1;
        check("rr_ready4", req_ready_o, 3'b010);
        cycle();
        check("rr_rd4", rd_addr_o, 5'd6);

        // Only requester 2 valid for three cycles, then all valid: wraps to 0.
        set_req(1, 1'b0, 5'd6, 32'hBBBB_0002);
        #1;
        check("solo2_ready_a", req_ready_o, 3'b100);
        cycle();
        check("solo2_rd_a", rd_addr_o, 5'd7);
        check("solo2_ready_b", req_ready_o, 3'b100);
        cycle();
        check("solo2_rd_b", rd_addr_o, 5'd7);
        check("solo2_ready_c", req_ready_o, 3'b100);
        cycle();
        check("solo2_rd_c", rd_addr_o, 5'd7);
        set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
        set_req(1, 1'b1, 5'd6, 32'hBBBB_0002);
        #1;
        check("wrap_ready", req_ready_o, 3'b001);
        cycle();
        check("wrap_rd", rd_addr_o, 5'd5);
        set_req(0, 1'b0, 5'd5, 32'hAAAA_0001);
        cycle();
        check("drain_rd1", rd_addr_o, 5'd6);
        set_req(1, 1'b0, 5'd6, 32'hBBBB_0002);
        cycle();
        check("drain_rd2", rd_addr_o, 5'd7);
        set_req(2, 1'b0, 5'd7, 32'hCCCC_0003);

        // Idle: no grant, output returns to zero.
        #1;
        check("idle_ready", req_ready_o, 3'b000);
        cycle();
        check("idle_rd", rd_addr_o, 5'd0);
        check("idle_data", rd_wr_data_o, 32'h0);

        // Issue marks x9 pending; requester 1 later writes x9 and clears it.
        iss_valid_i   = 1'b1;
        iss_rd_addr_i = 5'd9;
        rs1_addr_i    = 5'd9;
        rs2_addr_i    = 5'd9;
        #1;
        check("sb_no_bypass", rs1_busy_o, 1'b0);
        cycle();
        iss_valid_i = 1'b0;
        check("sb_set9", busy_o, 32'h0000_0200);
        check("sb_rs1_set9", rs1_busy_o, 1'b1);
        check("sb_rs2_set9", rs2_busy_o, 1'b1);
        set_req(1, 1'b1, 5'd9, 32'h0000_0099);
        #1;
        check("sb_wr_ready", req_ready_o, 3'b010);
        cycle();
        set_req(1, 1'b0, 5'd9, 32'h0000_0099);
        check("sb_wr_rd", rd_addr_o, 5'd9);
        check("sb_wr_data", rd_wr_data_o, 32'h0000_0099);
        check("sb_still_busy", rs1_busy_o, 1'b1);
        cycle();
        check("sb_cleared", busy_o, 32'h0);
        check("sb_rs1_cleared", rs1_busy_o, 1'b0);

        // Re-issue x9 while requester 2 writes x9; then set on the clearing edge.
        set_req(2, 1'b1, 5'd9, 32'h0000_1234);
        iss_valid_i   = 1'b1;
        iss_rd_addr_i = 5'd9;
        #1;
        check("sw_ready", req_ready_o, 3'b100);
        cycle();
        set_req(2, 1'b0, 5'd9, 32'h0000_1234);
        check("sw_rd", rd_addr_o, 5'd9);
        check("sw_busy_pre", busy_o, 32'h0000_0200);
        cycle();
        iss_valid_i = 1'b0;
        check("set_wins", busy_o, 32'h0000_0200);
        check("sw_idle_rd", rd_addr_o, 5'd0);

        // Clear x9 and set x11 on the same edge.
        set_req(0, 1'b1, 5'd9, 32'h0000_5555);
        #1;
        check("diff_ready", req_ready_o, 3'b001);
        cycle();
        set_req(0, 1'b0, 5'd9, 32'h0000_5555);
        check("diff_rd", rd_addr_o, 5'd9);
        iss_valid_i   = 1'b1;
        iss_rd_addr_i = 5'd11;
        rs2_addr_i    = 5'd11;
        cycle();
        iss_valid_i = 1'b0;
        check("set_clear_diff", busy_o, 32'h0000_0800);
        check("diff_rs1_9", rs1_busy_o, 1'b0);
        check("diff_rs2_11", rs2_busy_o, 1'b1);

        // Write to a register that is not pending leaves the scoreboard alone.
        set_req(1, 1'b1, 5'd3, 32'h0000_0333);
        #1;
        check("nb_ready", req_ready_o, 3'b010);
        cycle();
        set_req(1, 1'b0, 5'd3, 32'h0000_0333);
        check("nb_rd", rd_addr_o, 5'd3);
        cycle();
        check("nb_busy", busy_o, 32'h0000_0800);

        // Write to x0: accepted, rd_addr_o stays 0, pointer advances; issue to x0 ignored.
        set_req(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        iss_valid_i   = 1'b1;
        iss_rd_addr_i = 5'd0;
        #1;
        check("x0_ready", req_ready_o, 3'b001);
        cycle();
        iss_valid_i = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'hDEAD_BEEF);
        check("x0_rd", rd_addr_o, 5'd0);
        check("x0_data", rd_wr_data_o, 32'hDEAD_BEEF);
        check("x0_busy", busy_o, 32'h0000_0800);
        set_req(0, 1'b1, 5'd4, 32'h0000_0444);
        set_req(1, 1'b1, 5'd12, 32'h00C0_FFEE);
        #1;
        check("x0_ptr_adv", req_ready_o, 3'b010);

        // Grant to x12, then reset in the following cycle.
        cycle();
        set_req(1, 1'b0, 5'd12, 32'h00C0_FFEE);
        check("pre_rst_rd", rd_addr_o, 5'd12);
        rst_i = 1'b0;
        #1;
        check("mid_rst_ready", req_ready_o, 3'b000);
        cycle();
        check("mid_rst_rd", rd_addr_o, 5'd0);
        check("mid_rst_data", rd_wr_data_o, 32'h0);
        check("mid_rst_busy", busy_o, 32'h0);
        rst_i = 1'b1;
        set_req(2, 1'b1, 5'd14, 32'h0000_0EEE);
        #1;
        check("post_rst_ready", req_ready_o, 3'b001);
        cycle();
        check("post_rst_rd", rd_addr_o, 5'd4);
        check("post_rst_data", rd_wr_data_o, 32'h0000_0444);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
